alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit ALU (operands a/b, 3-bit select s, 8-bit result y). It accepts operations over valid/ready handshakes and drives registered operands and select into the combinational ALU. It waits a fixed number of cycles, then captures the result and returns it tagged with the requester ID. The response is held under backpressure. It sits between the instruction issue logic and the single ALU instance.

## Interface
- ALU_LAT, 1: cycles operands are held on the ALU before y is captured; legal range 1..15
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_a, req0_b  in  4  requester 0 operands
- req0_s  in  3  requester 0 ALU select
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req1_valid, req1_a, req1_b, req1_s, req1_ready: same as requester 0
- alu_a, alu_b  out  4  registered operands to ALU
- alu_s  out  3  registered select to ALU
- alu_y  in  8  ALU result (combinational from alu_a/b/s)
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that issued the result
- rsp_y  out  8  captured result
- rsp_ready  in  1  consumer takes result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- Round-robin pointer `last` records the requester most recently granted. Reset value is 1, so requester 0 wins first.
- IDLE:
  - reqN_ready is combinational and asserts only for the arbitration winner.
  - If one requester is valid, it wins.
  - If both are valid, the requester not equal to `last` wins.
  - If neither is valid, both ready signals are 0.
  - Ready never asserts outside IDLE.
  - Requesters must not make valid depend on ready.
- Accept (IDLE, reqN_valid && reqN_ready):
  - Latch reqN_a/b/s into alu_a/b/s.
  - Latch N into rsp_id and `last`.
  - Load the wait counter with ALU_LAT-1.
  - Go to EXEC.
- EXEC:
  - alu_a/b/s are held stable.
  - While the counter is nonzero it decrements.
  - When the counter is 0: capture rsp_y <= alu_y, set rsp_valid <= 1, go to DONE.
- DONE:
  - rsp_valid, rsp_y and rsp_id are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE.
  - No new operation is accepted in the handshake cycle.
- alu_a/b/s keep their last values after completion; they are not cleared.
- rsp_ready is ignored whenever rsp_valid is 0.
- Widths: operands pass through unmodified. The arbiter performs no arithmetic on the data; y is captured full 8-bit as returned.

## Timing
- Reset values: state IDLE, `last`=1, counter 0, alu_a=alu_b=0, alu_s=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, req0_ready=req1_ready=0.
- rst mid-operation (EXEC or DONE): the operation is discarded and no response is produced. All registers return to reset values on that edge, including `last`=1.
- Latency, accept cycle = T:
  - alu_a/b/s are valid from T+1.
  - EXEC occupies T+1 .. T+ALU_LAT.
  - rsp_valid is high from T+ALU_LAT+1.
- Throughput with rsp_ready tied high: one operation per ALU_LAT+2 cycles. For ALU_LAT=1, accepts occur at T, T+3, T+6, and so on.
- Counter wrap: the counter never decrements below 0. ALU_LAT=1 gives exactly one EXEC cycle.
- Simultaneous events:
  - A request arriving in DONE while rsp_ready is high waits until IDLE on the next cycle.
  - Both requesters held valid continuously are granted in strict alternation.

## Test plan
Bench ALU stub: alu_y = {alu_a, alu_b}; ALU_LAT=1 unless noted.
- Reset: assert rst 2 cycles with both requesters valid -> all outputs at reset values, both ready signals 0 during rst; first accept goes to requester 0 on the cycle after rst deasserts.
- Single op: req0 a=1001, b=0011, s=000, rsp_ready=1 -> accept at T; alu_s=000 at T+1; rsp_valid at T+2 with rsp_id=0, rsp_y=8'b1001_0011; IDLE at T+3.
- Fairness: both requesters valid continuously, req1 a=1101, b=1011, s=011 -> grant sequence 0,1,0,1; each rsp_id matches its grant; accepts spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_y and rsp_id stable, both ready signals 0, busy=1; rsp_ready=1 -> IDLE on the next cycle.
- Latency parameter: ALU_LAT=4, req1 a=0101, b=1011, s=111 -> alu inputs stable T+1..T+4; rsp_valid at T+5, rsp_y=8'b0101_1011.
- Reset mid-operation: rst in EXEC, and separately in DONE -> rsp_valid never asserts for the discarded op; the next grant goes to requester 0 even if requester 0 was the last granted.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for one shared combinational ALU.
// Two requesters hand over operations; results return tagged with the requester ID.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    input  logic [3:0] i_req0_a,
    input  logic [3:0] i_req0_b,
    input  logic [2:0] i_req0_s,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [3:0] i_req1_a,
    input  logic [3:0] i_req1_b,
    input  logic [2:0] i_req1_s,
    output logic       o_req1_ready,
    output logic [3:0] o_alu_a,
    output logic [3:0] o_alu_b,
    output logic [2:0] o_alu_s,
    input  logic [7:0] i_alu_y,
    output logic       o_rsp_valid,
    output logic       o_rsp_id,
    output logic [7:0] o_rsp_y,
    input  logic       i_rsp_ready,
    output logic       o_busy
);

    localparam logic [3:0] CntInit = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e     r_state;
    state_e     w_state_d;
    logic       r_last;
    logic [3:0] r_cnt;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [2:0] r_alu_s;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_y;

    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_exec_end;

    // On a tie the requester that was not granted last wins; nothing is granted while in reset.
    assign w_grant0   = !i_rst && (r_state == StIdle) && i_req0_valid
                        && (!i_req1_valid || r_last);
    assign w_grant1   = !i_rst && (r_state == StIdle) && i_req1_valid
                        && (!i_req0_valid || !r_last);
    assign w_accept   = w_grant0 || w_grant1;
    assign w_exec_end = (r_state == StExec) && (r_cnt == 4'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept)    w_state_d = StExec;
            StExec:  if (w_exec_end)  w_state_d = StDone;
            StDone:  if (i_rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last      <= 1'b1;
            r_cnt       <= 4'd0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_s     <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_y     <= 8'd0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_grant1 ? i_req1_a : i_req0_a;
                r_alu_b  <= w_grant1 ? i_req1_b : i_req0_b;
                r_alu_s  <= w_grant1 ? i_req1_s : i_req0_s;
                r_rsp_id <= w_grant1;
                r_last   <= w_grant1;
                r_cnt    <= CntInit;
            end
            if ((r_state == StExec) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_exec_end) begin
                r_rsp_y     <= i_alu_y;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == StDone) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_s      = r_alu_s;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_y      = r_rsp_y;
    assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, hand sequences and a random run
// against a transaction-level model. A second instance covers ALU_LAT=4.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       v0, v1, r0, r1;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] s0, s1;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_y;
    logic       rsp_valid, rsp_id, rsp_ready, busy;
    logic [7:0] rsp_y;

    logic       p_v0, p_v1, p_r0, p_r1;
    logic [3:0] p_a0, p_b0, p_a1, p_b1;
    logic [2:0] p_s0, p_s1;
    logic [3:0] p_alu_a, p_alu_b;
    logic [2:0] p_alu_s;
    logic [7:0] p_alu_y;
    logic       p_rsp_valid, p_rsp_id, p_rsp_ready, p_busy;
    logic [7:0] p_rsp_y;

    int n_cmp = 0;
    int n_err = 0;

    assign alu_y   = {alu_a, alu_b};
    assign p_alu_y = {p_alu_a, p_alu_b};

    alu_arbiter #(.ALU_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_s(s0), .o_req0_ready(r0),
        .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_s(s1), .o_req1_ready(r1),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_s(alu_s), .i_alu_y(alu_y),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_y(rsp_y),
        .i_rsp_ready(rsp_ready), .o_busy(busy)
    );

    alu_arbiter #(.ALU_LAT(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(p_v0), .i_req0_a(p_a0), .i_req0_b(p_b0), .i_req0_s(p_s0),
        .o_req0_ready(p_r0),
        .i_req1_valid(p_v1), .i_req1_a(p_a1), .i_req1_b(p_b1), .i_req1_s(p_s1),
        .o_req1_ready(p_r1),
        .o_alu_a(p_alu_a), .o_alu_b(p_alu_b), .o_alu_s(p_alu_s), .i_alu_y(p_alu_y),
        .o_rsp_valid(p_rsp_valid), .o_rsp_id(p_rsp_id), .o_rsp_y(p_rsp_y),
        .i_rsp_ready(p_rsp_ready), .o_busy(p_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       v0, v1;
        logic [3:0] a0, b0, a1, b1;
        logic [2:0] s0, s1;
        logic       er0, er1;
        logic       eid;
        logic [7:0] ey;
    } vec_t;

    vec_t vecs[6];

    // Single operation from IDLE to completion with rsp_ready held high.
    task automatic table_op(input int idx, input vec_t t);
        int k;
        @(negedge clk);
        v0 = t.v0; v1 = t.v1; a0 = t.a0; b0 = t.b0; s0 = t.s0;
        a1 = t.a1; b1 = t.b1; s1 = t.s1; rsp_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d ready0", idx), 32'(r0), 32'(t.er0));
        chk($sformatf("vec%0d ready1", idx), 32'(r1), 32'(t.er1));
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        #1;
        chk($sformatf("vec%0d alu_a", idx), 32'(alu_a), 32'(t.eid ? t.a1 : t.a0));
        chk($sformatf("vec%0d alu_b", idx), 32'(alu_b), 32'(t.eid ? t.b1 : t.b0));
        chk($sformatf("vec%0d alu_s", idx), 32'(alu_s), 32'(t.eid ? t.s1 : t.s0));
        chk($sformatf("vec%0d busy", idx), 32'(busy), 32'd1);
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk($sformatf("vec%0d latency", idx), 32'(k), 32'd2);
        chk($sformatf("vec%0d rsp_id", idx), 32'(rsp_id), 32'(t.eid));
        chk($sformatf("vec%0d rsp_y", idx), 32'(rsp_y), 32'(t.ey));
        @(negedge clk); #1;
        chk($sformatf("vec%0d idle busy", idx), 32'(busy), 32'd0);
        chk($sformatf("vec%0d idle rsp_valid", idx), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int k;
        int g_id[$];
        int g_cyc[$];
        logic       m_free, m_last, m_id, has, win;
        logic [3:0] m_a, m_b;
        logic [2:0] m_s;
        logic [7:0] m_y;
        int         m_rsp_at;

        rst = 1'b1; v0 = 0; v1 = 0; a0 = 0; b0 = 0; s0 = 0; a1 = 0; b1 = 0; s1 = 0;
        rsp_ready = 1'b1;
        p_v0 = 0; p_v1 = 0; p_a0 = 0; p_b0 = 0; p_s0 = 0; p_a1 = 0; p_b1 = 0; p_s1 = 0;
        p_rsp_ready = 1'b1;

        // Reset with both requesters valid, then first grant and a single op.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
            a0 = 4'b1001; b0 = 4'b0011; s0 = 3'b000; a1 = 4'b1101; b1 = 4'b1011; s1 = 3'b011;
            #1;
            chk("rst ready0", 32'(r0), 32'd0);
            chk("rst ready1", 32'(r1), 32'd0);
        end
        chk("rst alu_a", 32'(alu_a), 32'd0);
        chk("rst alu_s", 32'(alu_s), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_y", 32'(rsp_y), 32'd0);
        chk("rst rsp_id", 32'(rsp_id), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first ready0", 32'(r0), 32'd1);
        chk("first ready1", 32'(r1), 32'd0);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        #1;
        chk("single alu_s", 32'(alu_s), 32'd0);
        chk("single rsp_valid T+1", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        chk("single rsp_valid T+2", 32'(rsp_valid), 32'd1);
        chk("single rsp_id", 32'(rsp_id), 32'd0);
        chk("single rsp_y", 32'(rsp_y), 32'h93);
        @(negedge clk); #1;
        chk("single idle", 32'(busy), 32'd0);

        // Vector table; expected IDs follow the round-robin rule from last=1.
        vecs[0] = '{1, 0, 4'h9, 4'h3, 4'h0, 4'h0, 3'd0, 3'd0, 1, 0, 0, 8'h93};
        vecs[1] = '{1, 1, 4'h1, 4'h2, 4'hD, 4'hB, 3'd5, 3'd3, 0, 1, 1, 8'hDB};
        vecs[2] = '{1, 1, 4'h1, 4'h2, 4'hD, 4'hB, 3'd5, 3'd3, 1, 0, 0, 8'h12};
        vecs[3] = '{0, 1, 4'h7, 4'h7, 4'h5, 4'hB, 3'd1, 3'd7, 0, 1, 1, 8'h5B};
        vecs[4] = '{0, 1, 4'h7, 4'h7, 4'hF, 4'h0, 3'd1, 3'd2, 0, 1, 1, 8'hF0};
        vecs[5] = '{1, 1, 4'h0, 4'hF, 4'h3, 4'h3, 3'd6, 3'd4, 1, 0, 0, 8'h0F};
        rst_pulse();
        for (int i = 0; i < 6; i++) table_op(i, vecs[i]);

        // Fairness: both valid continuously.
        rst_pulse();
        a0 = 4'b1001; b0 = 4'b0011; s0 = 3'b000; a1 = 4'b1101; b1 = 4'b1011; s1 = 3'b011;
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            v0 = 1'b1; v1 = 1'b1;
            #1;
            if (rsp_valid && g_id.size() > 0) begin
                chk("fair rsp_id", 32'(rsp_id), 32'(g_id[$]));
                chk("fair rsp_y", 32'(rsp_y), (g_id[$] == 1) ? 32'hDB : 32'h93);
            end
            if (r0 || r1) begin
                g_id.push_back(r1 ? 1 : 0);
                g_cyc.push_back(i);
            end
        end
        chk("fair grant count", 32'(g_id.size()), 32'd4);
        for (int i = 0; i < g_id.size(); i++) begin
            chk($sformatf("fair grant%0d id", i), 32'(g_id[i]), 32'(i % 2));
            chk($sformatf("fair grant%0d cycle", i), 32'(g_cyc[i]), 32'(3 * i));
        end

        // Backpressure on the response.
        rst_pulse();
        @(negedge clk);
        v1 = 1'b1; a1 = 4'h6; b1 = 4'hC; s1 = 3'd2; rsp_ready = 1'b0;
        @(negedge clk);
        v1 = 1'b0;
        k = 0;
        #1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp rsp_y", 32'(rsp_y), 32'h6C);
            chk("bp rsp_id", 32'(rsp_id), 32'd1);
            chk("bp ready0", 32'(r0), 32'd0);
            chk("bp ready1", 32'(r1), 32'd0);
            chk("bp busy", 32'(busy), 32'd1);
            chk("bp hold valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp release busy", 32'(busy), 32'd0);
        chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp next ready0", 32'(r0), 32'd1);
        chk("bp next ready1", 32'(r1), 32'd0);
        v0 = 1'b0; v1 = 1'b0;

        // Reset during EXEC.
        @(negedge clk);
        v0 = 1'b1; a0 = 4'hA; b0 = 4'h5;
        #1;
        chk("rexec ready0", 32'(r0), 32'd1);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        chk("rexec busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rexec no rsp", 32'(rsp_valid), 32'd0);
            chk("rexec idle", 32'(busy), 32'd0);
            @(negedge clk);
        end
        v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("rexec regrant0", 32'(r0), 32'd1);
        chk("rexec regrant1", 32'(r1), 32'd0);
        v0 = 1'b0; v1 = 1'b0;

        // Reset during DONE.
        @(negedge clk);
        v0 = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk); #1;
        chk("rdone rsp_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rdone no rsp", 32'(rsp_valid), 32'd0);
            chk("rdone rsp_y", 32'(rsp_y), 32'd0);
            @(negedge clk);
        end
        v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("rdone regrant0", 32'(r0), 32'd1);
        chk("rdone regrant1", 32'(r1), 32'd0);
        v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;

        // ALU_LAT=4 instance.
        @(negedge clk);
        p_v1 = 1'b1; p_a1 = 4'b0101; p_b1 = 4'b1011; p_s1 = 3'b111;
        #1;
        chk("lat4 ready1", 32'(p_r1), 32'd1);
        @(negedge clk);
        p_v1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("lat4 T+%0d alu_a", i), 32'(p_alu_a), 32'h5);
            chk($sformatf("lat4 T+%0d alu_b", i), 32'(p_alu_b), 32'hB);
            chk($sformatf("lat4 T+%0d alu_s", i), 32'(p_alu_s), 32'h7);
            chk($sformatf("lat4 T+%0d rsp_valid", i), 32'(p_rsp_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("lat4 rsp_valid", 32'(p_rsp_valid), 32'd1);
        chk("lat4 rsp_y", 32'(p_rsp_y), 32'h5B);
        chk("lat4 rsp_id", 32'(p_rsp_id), 32'd1);

        // Random traffic against a transaction model: an op accepted at cycle c
        // responds from c+ALU_LAT+1 and frees the arbiter the cycle after its handshake.
        rst_pulse();
        m_free = 1'b1; m_last = 1'b1; m_id = 1'b0;
        m_a = '0; m_b = '0; m_s = '0; m_y = '0; m_rsp_at = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            v0 = ($urandom_range(0, 1) == 1);
            v1 = ($urandom_range(0, 1) == 1);
            a0 = 4'($urandom); b0 = 4'($urandom); s0 = 3'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); s1 = 3'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            has = m_free && (v0 || v1);
            win = (v0 && v1) ? !m_last : v1;
            chk("rnd ready0", 32'(r0), 32'(has && !win));
            chk("rnd ready1", 32'(r1), 32'(has && win));
            chk("rnd busy", 32'(busy), 32'(!m_free));
            chk("rnd rsp_valid", 32'(rsp_valid), 32'(!m_free && c >= m_rsp_at));
            chk("rnd alu_a", 32'(alu_a), 32'(m_a));
            chk("rnd alu_b", 32'(alu_b), 32'(m_b));
            chk("rnd alu_s", 32'(alu_s), 32'(m_s));
            if (!m_free && c >= m_rsp_at) begin
                chk("rnd rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rnd rsp_y", 32'(rsp_y), 32'(m_y));
            end
            if (has) begin
                m_free = 1'b0;
                m_rsp_at = c + 2;
                m_a = win ? a1 : a0;
                m_b = win ? b1 : b0;
                m_s = win ? s1 : s0;
                m_y = {m_a, m_b};
                m_id = win;
                m_last = win;
            end else if (!m_free && c >= m_rsp_at && rsp_ready) begin
                m_free = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
